// File: rtl/zram_arbiter_if.sv
// Master-side bundle of the shared RAM arbiter:
// per-port request, write, address and data, plus ack/rdata.
interface zram_arbiter_if #(
  parameter int NPORTS = 3,
  parameter int AW     = 16,
  parameter int DW     = 8
) ();
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] wdata;
  logic [NPORTS-1:0]    ack;
  logic [DW-1:0]        rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/zram_arbiter.sv
// Shared single-port RAM arbiter: NPORTS masters,
// optional fixed priority for port 0, round-robin otherwise.
module zram_arbiter #(
  parameter int NPORTS      = 3,
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int RAM_LATENCY = 1,
  parameter int PRIO0       = 1
) (
  input  logic          clock,
  input  logic          reset,
  zram_arbiter_if.slave bus,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);
  localparam int PW = $clog2(NPORTS);
  localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     w_q, w_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              wren_q, wren_d;

  logic [PW-1:0]     win;
  logic              found;
  int                idx;

  // Port 0 may bypass the scan; the scan itself starts at rr_q.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (PRIO0 != 0 && bus.req[0]) begin
      win   = '0;
      found = 1'b1;
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        idx = (int'(rr_q) + k) % NPORTS;
        if (!found && bus.req[idx] &&
            !(PRIO0 != 0 && idx == 0)) begin
          win   = PW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          w_d     = win;
          addr_d  = bus.addr[win*AW +: AW];
          data_d  = bus.wdata[win*DW +: DW];
          wren_d  = bus.we[win];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(RAM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_DONE;
          ack_d[w_q] = 1'b1;
          rdata_d    = ram_q;
          rr_d       = (w_q == PW'(NPORTS - 1)) ?
                       '0 : w_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = wren_q;
endmodule

// File: tb/tb_zram_arbiter.sv
// Bench for zram_arbiter: three instances (prio/lat1,
// round-robin/lat1, prio/lat4) each with a RAM model.
module tb_zram_arbiter;
  typedef struct {
    int         port;
    logic [7:0] data;
    bit         chk;
  } exp_t;

  typedef struct {
    int         port;
    bit         we;
    logic [15:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    bit         chk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic [2:0]  req_s  [3];
  logic [2:0]  we_s   [3];
  logic [47:0] addr_s [3];
  logic [23:0] wd_s   [3];
  logic [2:0]  ack_s  [3];
  logic [7:0]  rd_s   [3];
  logic [15:0] ra_s   [3];
  logic [7:0]  rdat_s [3];
  logic        wren_s [3];

  int   checks = 0;
  int   errors = 0;
  int   wcnt [3];
  exp_t sbq [3][$];
  vec_t tbl [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int L = (g == 2) ? 4 : 1;
    zram_arbiter_if #(.NPORTS(3), .AW(16), .DW(8)) bus ();
    logic [7:0] q;
    logic [7:0] mem  [65536];
    logic [7:0] pipe [L];

    assign bus.req   = req_s[g];
    assign bus.we    = we_s[g];
    assign bus.addr  = addr_s[g];
    assign bus.wdata = wd_s[g];
    assign ack_s[g]  = bus.ack;
    assign rd_s[g]   = bus.rdata;

    zram_arbiter #(
      .NPORTS(3), .AW(16), .DW(8),
      .RAM_LATENCY(L),
      .PRIO0((g == 1) ? 0 : 1)
    ) u_dut (
      .clock(clk),
      .reset(rst[g]),
      .bus(bus),
      .ram_address(ra_s[g]),
      .ram_data(rdat_s[g]),
      .ram_wren(wren_s[g]),
      .ram_q(q)
    );

    initial begin
      for (int a = 0; a < 65536; a++)
        mem[a] = 8'(a) ^ 8'(a >> 8);
      mem[16'h1234] = 8'hA5;
    end

    always @(posedge clk) begin
      if (wren_s[g]) mem[ra_s[g]] <= rdat_s[g];
      pipe[0] <= mem[ra_s[g]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign q = pipe[L-1];
  end

  // Scoreboard: every ack pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (wren_s[i]) wcnt[i]++;
      if (ack_s[i] != 3'b000) begin
        checks++;
        if (sbq[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack inst %0d ack %b", i, ack_s[i]);
        end else begin
          e = sbq[i].pop_front();
          if (ack_s[i] != 3'(1 << e.port)) begin
            errors++;
            $display("FAIL ack_port inst %0d got %b exp port %0d",
                     i, ack_s[i], e.port);
          end
          if (e.chk) begin
            checks++;
            if (rd_s[i] !== e.data) begin
              errors++;
              $display("FAIL rdata inst %0d got %h exp %h",
                       i, rd_s[i], e.data);
            end
          end
        end
      end
    end
  end

  task automatic chk_int(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic push(int inst, int port, logic [7:0] d, bit c);
    exp_t e;
    e.port = port;
    e.data = d;
    e.chk  = c;
    sbq[inst].push_back(e);
  endtask

  task automatic wait_ack(int inst, int maxc, output int n);
    for (n = 1; n <= maxc; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_s[inst] != 3'b000) return;
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout inst %0d after %0d cycles", inst, maxc);
  endtask

  task automatic set_port(int inst, int p, bit w,
                          logic [15:0] a, logic [7:0] d);
    we_s[inst][p]          = w;
    addr_s[inst][p*16 +: 16] = a;
    wd_s[inst][p*8 +: 8]   = d;
  endtask

  task automatic do_access(int inst, vec_t v);
    int n;
    int w0;
    @(negedge clk);
    w0 = wcnt[inst];
    set_port(inst, v.port, v.we, v.a, v.d);
    req_s[inst][v.port] = 1'b1;
    push(inst, v.port, v.exp, v.chk);
    wait_ack(inst, 20, n);
    chk_int("latency", n, (inst == 2) ? 6 : 3);
    chk_int("wren_pulses", wcnt[inst] - w0, int'(v.we));
    req_s[inst][v.port] = 1'b0;
    we_s[inst][v.port]  = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1};
    tbl[1] = '{2, 1'b1, 16'h00FF, 8'h3C, 8'h00, 1'b0};
    tbl[2] = '{1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b1};
    tbl[3] = '{0, 1'b0, 16'h0003, 8'h00, 8'h03, 1'b1};
    tbl[4] = '{0, 1'b1, 16'h0100, 8'h77, 8'h00, 1'b0};
    tbl[5] = '{2, 1'b0, 16'h0100, 8'h00, 8'h77, 1'b1};
    tbl[6] = '{1, 1'b0, 16'hABCD, 8'h00, 8'h66, 1'b1};
    tbl[7] = '{2, 1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b1};
    for (int i = 0; i < 3; i++) begin
      rst[i]    = 1'b1;
      req_s[i]  = '0;
      we_s[i]   = '0;
      addr_s[i] = '0;
      wd_s[i]   = '0;
      wcnt[i]   = 0;
    end

    // Reset held with all requests high
    set_port(0, 0, 1'b0, 16'h0042, 8'h00);
    req_s[0] = 3'b111;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk_int("rst_ack", int'(ack_s[i]), 0);
        chk_int("rst_wren", int'(wren_s[i]), 0);
        chk_int("rst_rdata", int'(rd_s[i]), 0);
      end
    end
    rst[0] = 1'b0;
    push(0, 0, 8'h42, 1'b1);
    wait_ack(0, 20, n);
    chk_int("post_rst_latency", n, 3);
    req_s[0] = 3'b000;

    for (int i = 0; i < 8; i++) do_access(0, tbl[i]);
    repeat (3) @(negedge clk);
    chk_int("rdata_hold", int'(rd_s[0]), 8'h3C);

    // Priority: port 0 wins, then 1/2 alternate from rr
    set_port(0, 0, 1'b0, 16'h0010, 8'h00);
    set_port(0, 1, 1'b0, 16'h0201, 8'h00);
    set_port(0, 2, 1'b0, 16'h0302, 8'h00);
    push(0, 0, 8'h10, 1'b1);
    push(0, 0, 8'h10, 1'b1);
    push(0, 0, 8'h10, 1'b1);
    push(0, 1, 8'h03, 1'b1);
    push(0, 2, 8'h01, 1'b1);
    push(0, 1, 8'h03, 1'b1);
    push(0, 2, 8'h01, 1'b1);
    req_s[0] = 3'b111;
    for (int k = 0; k < 7; k++) begin
      wait_ack(0, 20, n);
      chk_int("prio_gap", n, (k == 0) ? 3 : 4);
      if (k == 2) req_s[0][0] = 1'b0;
    end
    req_s[0] = 3'b000;

    // Pure round-robin on instance 1
    @(negedge clk);
    set_port(1, 0, 1'b0, 16'h0010, 8'h00);
    set_port(1, 1, 1'b0, 16'h0201, 8'h00);
    set_port(1, 2, 1'b0, 16'h0302, 8'h00);
    for (int k = 0; k < 2; k++) begin
      push(1, 0, 8'h10, 1'b1);
      push(1, 1, 8'h03, 1'b1);
      push(1, 2, 8'h01, 1'b1);
    end
    rst[1]   = 1'b0;
    req_s[1] = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(1, 20, n);
      chk_int("rr_gap", n, (k == 0) ? 3 : 4);
    end
    req_s[1] = 3'b000;

    // Latency 4, then reset in the middle of WAIT
    @(negedge clk);
    rst[2] = 1'b0;
    do_access(2, tbl[0]);
    @(negedge clk);
    set_port(2, 1, 1'b0, 16'h00AA, 8'h00);
    req_s[2][1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    chk_int("midrst_ack", int'(ack_s[2]), 0);
    chk_int("midrst_wren", int'(wren_s[2]), 0);
    chk_int("midrst_state", int'(g_i[2].u_dut.state_q), 0);
    @(negedge clk);
    chk_int("midrst_ack2", int'(ack_s[2]), 0);
    rst[2] = 1'b0;
    push(2, 1, 8'hAA, 1'b1);
    wait_ack(2, 20, n);
    chk_int("regrant_latency", n, 6);
    req_s[2] = 3'b000;

    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk_int("sb_empty", sbq[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
